pwm_capture: RTL and testbench

//  Receive side of the trapezoid PWM path: measures an incoming PWM waveform and recovers
//  its high time, period and 8-bit duty code. D matches the TW code that produced it
//  (high time = TW*8 CLK). Sits on the feedback side of the stepper loop and checks or

---
 rtl/pwm_capture.sv | 180 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receive-side capture: measures high time, period and 8-bit duty code of PWMIN.
// Optional glitch filter on the synchronized level: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W    = 12,
    parameter int DSHIFT   = 3,
    parameter int FILT_LEN = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             PWMIN,
    output logic [CNT_W-1:0] HIGH,
    output logic [CNT_W-1:0] PERIOD,
    output logic [7:0]       D,
    output logic             VALID,
    output logic             STUCK,
    output logic             ZERO
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, HI, LO} state_t;

    state_t           state, state_n;
    logic             s1, s2, lv, lvd;
    logic             rise, fall, settled;
    logic [CNT_W-1:0] pcnt, pcnt_n, hcnt, hcnt_n;
    logic             commit, tmo;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= PWMIN;
            s2 <= s1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FILL_MAX = 2 + FILT_LEN;
    localparam int FW       = $clog2(FILT_LEN + 1);

    logic [FW-1:0] fcnt;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            lv   <= 1'b0;
            fcnt <= '0;
        end else if (s2 != lv) begin
            if (fcnt == FW'(FILT_LEN - 1)) begin
                lv   <= s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else begin
            fcnt <= '0;
        end
    end
`else
    localparam int FILL_MAX = 2;

    assign lv = s2;
`endif

    // The level is only trusted once reset-cleared pipeline flops hold real samples,
    // otherwise a line that is high at release looks like a fresh low-to-high edge.
    localparam int FLW = $clog2(FILL_MAX + 1);

    logic [FLW-1:0] fill;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fill <= '0;
            lvd  <= 1'b0;
        end else begin
            lvd <= lv;
            if (fill != FLW'(FILL_MAX))
                fill <= fill + 1'b1;
        end
    end

    assign settled = (fill == FLW'(FILL_MAX));
    assign rise    = lv & ~lvd;
    assign fall    = ~lv & lvd;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= IDLE;
            pcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            hcnt  <= hcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        hcnt_n  = hcnt;
        commit  = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE: begin
                pcnt_n = '0;
                hcnt_n = '0;
                if (settled && !lv)
                    state_n = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    state_n = HI;
                    pcnt_n  = CNT_W'(1);
                    hcnt_n  = CNT_W'(1);
                end
            end
            HI: begin
                if (pcnt == CMAX) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                    if (fall)
                        state_n = LO;
                    else
                        hcnt_n = hcnt + 1'b1;
                end
            end
            LO: begin
                // A rise arriving together with the timeout still commits.
                if (rise) begin
                    commit  = 1'b1;
                    state_n = HI;
                    pcnt_n  = CNT_W'(1);
                    hcnt_n  = CNT_W'(1);
                end else if (pcnt == CMAX) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] sh;
        sh = v >> DSHIFT;
        return ((sh >> 8) != '0) ? 8'hFF : sh[7:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            HIGH   <= '0;
            PERIOD <= '0;
            D      <= 8'h00;
            VALID  <= 1'b0;
            STUCK  <= 1'b0;
        end else begin
            VALID <= commit | tmo;
            if (commit) begin
                HIGH   <= hcnt;
                PERIOD <= pcnt;
                D      <= sat8(hcnt);
                STUCK  <= 1'b0;
            end else if (tmo) begin
                HIGH   <= lv ? CMAX : '0;
                PERIOD <= '0;
                D      <= lv ? 8'hFF : 8'h00;
                STUCK  <= 1'b1;
            end
        end
    end

    assign ZERO = (D == 8'h00);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture; every VALID pulse is logged and
// compared against hand-computed HIGH/PERIOD/D/STUCK/ZERO values.
module tb_pwm_capture;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        PWMIN;
    logic [11:0] HIGH;
    logic [11:0] PERIOD;
    logic [7:0]  D;
    logic        VALID;
    logic        STUCK;
    logic        ZERO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] high;
        logic [11:0] period;
        logic [7:0]  d;
        logic        stuck;
        logic        zero;
    } snap_t;

    snap_t snaps[$];

    pwm_capture dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .PWMIN  (PWMIN),
        .HIGH   (HIGH),
        .PERIOD (PERIOD),
        .D      (D),
        .VALID  (VALID),
        .STUCK  (STUCK),
        .ZERO   (ZERO)
    );

    always #5 CLK = ~CLK;

    // Log every VALID cycle; a pulse stretched over two cycles shows up as an extra entry.
    always @(negedge CLK) begin
        if (VALID === 1'b1)
            snaps.push_back('{HIGH, PERIOD, D, STUCK, ZERO});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkEntry(input string tag, input int idx, input int h, input int p,
                              input int d, input int s, input int z);
        if (idx >= snaps.size()) begin
            checkOutput({tag, "_present"}, snaps.size(), idx + 1);
        end else begin
            checkOutput({tag, "_high"},   snaps[idx].high,   h);
            checkOutput({tag, "_period"}, snaps[idx].period, p);
            checkOutput({tag, "_d"},      snaps[idx].d,      d);
            checkOutput({tag, "_stuck"},  snaps[idx].stuck,  s);
            checkOutput({tag, "_zero"},   snaps[idx].zero,   z);
        end
    endtask

    task automatic applyStimulus(input int h, input int p);
        PWMIN = 1'b1;
        repeat (h) @(negedge CLK);
        PWMIN = 1'b0;
        repeat (p - h) @(negedge CLK);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_high"},   HIGH,   0);
        checkOutput({tag, "_period"}, PERIOD, 0);
        checkOutput({tag, "_d"},      D,      0);
        checkOutput({tag, "_valid"},  VALID,  0);
        checkOutput({tag, "_stuck"},  STUCK,  0);
        checkOutput({tag, "_zero"},   ZERO,   1);
    endtask

    initial begin
        PWMIN = 1'b0;
        RSTN  = 1'b0;
        repeat (4) @(negedge CLK);
        checkResetState("rst");
        RSTN = 1'b1;
        repeat (10) @(negedge CLK);
        snaps.delete();

        $display("[TB] steady 512/2048");
        repeat (4) applyStimulus(512, 2048);
        checkOutput("t1_count", snaps.size(), 3);
        for (int i = 0; i < 3; i++)
            checkEntry($sformatf("t1_%0d", i), i, 512, 2048, 'h40, 0, 0);
        snaps.delete();

        $display("[TB] duty ramp then line low");
        applyStimulus(8, 256);
        applyStimulus(16, 256);
        applyStimulus(24, 256);
        repeat (4400) @(negedge CLK);
        checkOutput("t2_count", snaps.size(), 4);
        checkEntry("t2_0", 0, 512, 2048, 'h40, 0, 0);
        checkEntry("t2_1", 1, 8, 256, 'h01, 0, 0);
        checkEntry("t2_2", 2, 16, 256, 'h02, 0, 0);
        checkEntry("t2_tmo", 3, 0, 0, 'h00, 1, 1);
        checkOutput("t2_stuck_level", STUCK, 1);
        snaps.delete();

        $display("[TB] line stuck high then recovery");
        applyStimulus(5000, 5000 + 1536);
        applyStimulus(512, 2048);
        applyStimulus(512, 2048);
        checkOutput("t3_count", snaps.size(), 2);
        checkEntry("t3_tmo", 0, 4095, 0, 'hFF, 1, 0);
        checkEntry("t3_rec", 1, 512, 2048, 'h40, 0, 0);
        checkOutput("t3_stuck_clr", STUCK, 0);
        snaps.delete();

        $display("[TB] saturated duty code");
        applyStimulus(2100, 3000);
        applyStimulus(2100, 3000);
        checkOutput("t4_count", snaps.size(), 2);
        checkEntry("t4_0", 0, 512, 2048, 'h40, 0, 0);
        checkEntry("t4_sat", 1, 2100, 3000, 'hFF, 0, 0);

        $display("[TB] reset mid high phase");
        PWMIN = 1'b1;
        repeat (100) @(negedge CLK);
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        checkResetState("t5_rst");
        RSTN = 1'b1;
        snaps.delete();
        repeat (409) @(negedge CLK);
        PWMIN = 1'b0;
        repeat (1536) @(negedge CLK);
        applyStimulus(512, 2048);
        applyStimulus(512, 2048);
        checkOutput("t5_count", snaps.size(), 1);
        checkEntry("t5_0", 0, 512, 2048, 'h40, 0, 0);
        snaps.delete();

        $display("[TB] short low glitch inside high phase");
        PWMIN = 1'b1;
        repeat (200) @(negedge CLK);
        PWMIN = 1'b0;
        repeat (2) @(negedge CLK);
        PWMIN = 1'b1;
        repeat (310) @(negedge CLK);
        PWMIN = 1'b0;
        repeat (1536) @(negedge CLK);
        applyStimulus(512, 2048);
        applyStimulus(20, 40);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        checkOutput("t6_count", snaps.size(), 3);
        checkEntry("t6_0", 0, 512, 2048, 'h40, 0, 0);
        checkEntry("t6_1", 1, 512, 2048, 'h40, 0, 0);
        checkEntry("t6_2", 2, 512, 2048, 'h40, 0, 0);
`else
        checkOutput("t6_count", snaps.size(), 4);
        checkEntry("t6_0", 0, 512, 2048, 'h40, 0, 0);
        checkEntry("t6_a", 1, 200, 202, 'h19, 0, 0);
        checkEntry("t6_b", 2, 310, 1846, 'h26, 0, 0);
        checkEntry("t6_3", 3, 512, 2048, 'h40, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
